// File: rtl/uart_tx_frame_ctrl_if.sv
// Byte-in / PISO-out signal bundle for the UART transmit frame controller.
// master = byte source and PISO side, slave = the controller.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_W  = 8,
    parameter int FRAME_W = DATA_W + 3
);
    logic [DATA_W-1:0]  data_in;
    logic               data_valid;
    logic               data_ready;
    logic [FRAME_W-1:0] piso_frame;
    logic               piso_enb;
    logic               piso_load;
    logic               piso_shift;
    logic               piso_hold;
    logic               busy;
    logic               tx_done;

    modport master (
        output data_in, data_valid,
        input  data_ready, piso_frame, piso_enb, piso_load, piso_shift,
               piso_hold, busy, tx_done
    );

    modport slave (
        input  data_in, data_valid,
        output data_ready, piso_frame, piso_enb, piso_load, piso_shift,
               piso_hold, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART frame builder and baud-rate strobe generator for an MSB-first PISO; LOAD one cycle after accept,
// frame done 1 + FRAME_W*CLK_DIV cycles after LOAD; data_ready stays low from LOAD until back in IDLE.
module uart_tx_frame_ctrl #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_W     = 8,
    parameter int FRAME_W    = DATA_W + 3,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    uart_tx_frame_ctrl_if.slave  bus
);
    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int BIT_W  = $clog2(FRAME_W);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [FRAME_W-1:0] frame_new;
    logic               baud_wrap;

    assign baud_wrap      = (baud_q == BAUD_W'(CLK_DIV - 1));
    assign bus.piso_frame = frame_q;

    // The PISO sends bit FRAME_W-1 first, so the payload is stored bit-reversed to go out LSB-first.
    always_comb begin
        frame_new = '0;
        for (int i = 0; i < DATA_W; i++) begin
            frame_new[FRAME_W-2-i] = bus.data_in[i];
        end
        frame_new[FRAME_W-1] = 1'b0;
        frame_new[1]         = (PARITY_ODD != 0) ? ~^bus.data_in : ^bus.data_in;
        frame_new[0]         = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            frame_q <= frame_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        baud_d         = baud_q;
        bit_d          = bit_q;
        frame_d        = frame_q;
        bus.data_ready = 1'b0;
        bus.piso_enb   = 1'b0;
        bus.piso_load  = 1'b0;
        bus.piso_shift = 1'b0;
        bus.piso_hold  = 1'b1;
        bus.busy       = 1'b0;
        bus.tx_done    = 1'b0;

        case (state_q)
            IDLE: begin
                bus.data_ready = 1'b1;
                if (bus.data_valid) begin
                    frame_d = frame_new;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                bus.piso_load = 1'b1;
                bus.piso_enb  = 1'b1;
                bus.busy      = 1'b1;
                baud_d        = '0;
                bit_d         = '0;
                state_d       = SHIFT;
            end
            SHIFT: begin
                bus.piso_hold = 1'b0;
                bus.busy      = 1'b1;
                if (baud_wrap) begin
                    baud_d = '0;
                    // The last bit period ends without a shift; the stop bit has already been presented.
                    if (bit_q == BIT_W'(FRAME_W - 1)) begin
                        state_d = DONE;
                    end else begin
                        bus.piso_shift = 1'b1;
                        bus.piso_enb   = 1'b1;
                        bit_d          = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DONE: begin
                bus.tx_done = 1'b1;
                bus.busy    = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Scoreboard bench: expected frames queued at send time, per-cycle timeline model of the strobes.
module tb_uart_tx_frame_ctrl;
    localparam int D         = 4;
    localparam int DW        = 8;
    localparam int FW        = 11;
    localparam int FRAME_CYC = FW * D;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx_frame_ctrl_if #(.DATA_W(DW), .FRAME_W(FW)) bus0 ();
    uart_tx_frame_ctrl_if #(.DATA_W(DW), .FRAME_W(FW)) bus1 ();

    uart_tx_frame_ctrl #(.CLK_DIV(D), .DATA_W(DW), .FRAME_W(FW), .PARITY_ODD(0)) dut_even (
        .clk(clk), .reset(reset), .bus(bus0)
    );
    uart_tx_frame_ctrl #(.CLK_DIV(D), .DATA_W(DW), .FRAME_W(FW), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .reset(reset), .bus(bus1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] mk_frame(input logic [DW-1:0] d, input bit odd);
        logic [FW-1:0] f;
        int ones;
        ones = 0;
        f[FW-1] = 1'b0;
        for (int i = 0; i < DW; i++) begin
            f[FW-2-i] = d[i];
            ones += int'(d[i]);
        end
        f[1] = odd ? (ones % 2 == 0) : (ones % 2 == 1);
        f[0] = 1'b1;
        return f;
    endfunction

    logic [FW-1:0] exp_q0[$];
    logic [FW-1:0] exp_q1[$];
    int  cyc = 0;
    int  m_rel = -1;
    bit  mon_en = 1'b0;
    int  load_cnt = 0, done_cnt = 0, done1_cnt = 0;
    int  load_cyc = 0, done_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Timeline model: m_rel = cycles since LOAD, -1 while idle.
    always @(negedge clk) begin
        if (mon_en) begin
            logic idle, ld, sh, dn;
            logic [6:0] got, exp;
            idle = (m_rel < 0);
            ld   = (m_rel == 0);
            sh   = (m_rel >= 1) && (m_rel < FRAME_CYC) && (m_rel % D == 0);
            dn   = (m_rel == FRAME_CYC + 1);
            exp  = {idle, idle | ld | dn, ~idle, ld, sh, ld | sh, dn};
            got  = {bus0.data_ready, bus0.piso_hold, bus0.busy, bus0.piso_load,
                    bus0.piso_shift, bus0.piso_enb, bus0.tx_done};
            check($sformatf("ctrl@rel%0d", m_rel), 32'(got), 32'(exp));
            if (bus0.piso_load) begin
                load_cnt <= load_cnt + 1;
                load_cyc <= cyc;
                check("sb_nonempty", 32'(exp_q0.size() != 0), 1);
                if (exp_q0.size() != 0) check("frame", 32'(bus0.piso_frame), 32'(exp_q0.pop_front()));
            end
            if (bus0.tx_done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
            if (reset)     m_rel <= -1;
            else if (idle) m_rel <= bus0.data_valid ? 0 : -1;
            else if (dn)   m_rel <= -1;
            else           m_rel <= m_rel + 1;

            if (bus1.piso_load) begin
                check("sb1_nonempty", 32'(exp_q1.size() != 0), 1);
                if (exp_q1.size() != 0) check("frame_odd", 32'(bus1.piso_frame), 32'(exp_q1.pop_front()));
            end
            if (bus1.tx_done) done1_cnt <= done1_cnt + 1;
        end
    end

    task automatic send(input logic [DW-1:0] b, input logic [FW-1:0] f);
        int n;
        n = 0;
        exp_q0.push_back(f);
        bus0.data_in    = b;
        bus0.data_valid = 1'b1;
        @(negedge clk);
        while (!bus0.data_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(bus0.data_ready), 1);
        @(posedge clk);
        #1 bus0.data_valid = 1'b0;
    endtask

    task automatic wait_done(input int tgt);
        int n;
        n = 0;
        while (done_cnt < tgt && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("done_reached", 32'(done_cnt >= tgt), 1);
        #1;
    endtask

    task automatic wait_loads(input int tgt);
        int n;
        n = 0;
        while (load_cnt < tgt && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("load_reached", 32'(load_cnt >= tgt), 1);
        #1;
    endtask

    task automatic wait_rel(input int tgt);
        int n;
        n = 0;
        while (m_rel != tgt && n < 500) begin
            @(posedge clk);
            n++;
        end
        check("rel_reached", 32'(m_rel == tgt), 1);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, l0;
        bus0.data_in    = 8'hFF;
        bus0.data_valid = 1'b1;
        bus1.data_in    = '0;
        bus1.data_valid = 1'b0;

        // Reset held with data_valid high: idle outputs, nothing latched.
        repeat (2) @(posedge clk);
        #1 mon_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_frame", 32'(bus0.piso_frame), 0);
        check("rst_loads", 32'(load_cnt), 0);
        @(posedge clk);
        #1 bus0.data_valid = 1'b0;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Spec example frames; tx_done follows LOAD, 11 bit periods, then DONE.
        send(8'h55, 11'h2A9);
        wait_done(1);
        check("lat_55", 32'(done_cyc - load_cyc), 32'(FRAME_CYC + 1));
        send(8'h80, 11'h007);
        wait_done(2);

        // Back-to-back with data_valid held high.
        exp_q0.push_back(mk_frame(8'h3C, 1'b0));
        exp_q0.push_back(mk_frame(8'hA5, 1'b0));
        bus0.data_in    = 8'h3C;
        bus0.data_valid = 1'b1;
        wait_loads(3);
        bus0.data_in = 8'hA5;
        wait_loads(4);
        bus0.data_valid = 1'b0;
        check("b2b_gap", 32'(load_cyc - done_cyc), 2);
        wait_done(4);

        // Reset in the 5th bit period aborts the frame without tx_done.
        send(8'h5A, mk_frame(8'h5A, 1'b0));
        wait_rel(4 * D + 2);
        reset = 1'b1;
        d0 = done_cnt;
        l0 = load_cnt;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        check("abort_no_done", 32'(done_cnt), 32'(d0));
        check("abort_no_load", 32'(load_cnt), 32'(l0));
        send(8'hC3, mk_frame(8'hC3, 1'b0));
        wait_done(d0 + 1);

        // data_valid pulsed mid-frame is ignored and never sent.
        send(8'h66, mk_frame(8'h66, 1'b0));
        wait_rel(2 * D + 1);
        bus0.data_in    = 8'h99;
        bus0.data_valid = 1'b1;
        @(posedge clk);
        #1 bus0.data_valid = 1'b0;
        wait_done(d0 + 2);
        repeat (20) @(posedge clk);
        #1;
        check("total_loads", 32'(load_cnt), 7);
        check("sb_drained", 32'(exp_q0.size()), 0);

        // Odd-parity instance.
        exp_q1.push_back(11'h005);
        bus1.data_in    = 8'h80;
        bus1.data_valid = 1'b1;
        @(posedge clk);
        #1 bus1.data_valid = 1'b0;
        for (int n = 0; n < 200 && done1_cnt == 0; n++) @(posedge clk);
        #1;
        check("odd_done", 32'(done1_cnt), 1);
        check("sb1_drained", 32'(exp_q1.size()), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
